// File: rtl/bp_me_wormhole_flit_serializer_pkg.sv
// Shared types and elaboration-time helpers for the wormhole flit serializer.
package bp_me_wormhole_flit_serializer_pkg;

  // Serializer control states: IDLE waits for a packet, SEND streams its flits.
  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_send = 1'b1
  } ser_state_e;

  // Counter/field width that never collapses to zero bits.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Integer ceiling division, used to size one flit.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/bp_me_wormhole_flit_serializer_counter.sv
// Flit index counter: synchronous clear on packet accept, increment per sent body flit.
module bp_me_wormhole_flit_serializer_counter #(
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q, count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (up_i) begin
      count_d = count_q + width_p'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bp_me_wormhole_flit_serializer_len_chk.sv
// Simulation-only check that an accepted packet's len field fits the flit budget.
module bp_me_wormhole_flit_serializer_len_chk #(
  parameter int max_num_flit_p = 4,
  parameter int len_width_p    = 2
) (
  input logic                   clk_i,
  input logic                   reset_i,
  input logic                   accept_i,
  input logic [len_width_p-1:0] len_i
);

  logic [31:0] len_ext_s;
  assign len_ext_s = 32'(len_i);

  // An oversized len is tolerated by the datapath (it saturates) but is reported.
  len_in_range_a: assert property (@(posedge clk_i) disable iff (reset_i)
      accept_i |-> (len_ext_s <= 32'(max_num_flit_p - 1)))
    else $warning("len field %0d exceeds max_num_flit_p-1, saturating", len_ext_s);

endmodule

// File: rtl/bp_me_wormhole_flit_serializer.sv
// Splits one wide coherence packet {payload, len, y_cord, x_cord} into
// router-width flits, head flit first, for one wormhole router input port.
module bp_me_wormhole_flit_serializer
  import bp_me_wormhole_flit_serializer_pkg::*;
#(
  parameter int max_num_flit_p       = 4,
  parameter int max_payload_width_p  = 26,
  parameter int x_cord_width_p       = 2,
  parameter int y_cord_width_p       = 2,
  localparam int len_width_lp    = safe_clog2(max_num_flit_p),
  localparam int packet_width_lp = x_cord_width_p + y_cord_width_p + len_width_lp + max_payload_width_p,
  localparam int flit_width_lp   = ceil_div(packet_width_lp, max_num_flit_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [packet_width_lp-1:0] packet_i,
  input  logic                       v_i,
  output logic                       ready_o,
  output logic [flit_width_lp-1:0]   data_o,
  output logic                       v_o,
  input  logic                       ready_i
);

  localparam int padded_width_lp = max_num_flit_p * flit_width_lp;
  localparam int len_lsb_lp      = x_cord_width_p + y_cord_width_p;
  localparam logic [len_width_lp-1:0] last_max_lp = len_width_lp'(max_num_flit_p - 1);

  ser_state_e                 state_q, state_d;
  logic [padded_width_lp-1:0] pkt_q, pkt_d;
  logic [len_width_lp-1:0]    last_q, last_d;
  logic [len_width_lp-1:0]    len_s;
  logic [len_width_lp-1:0]    cnt_s;
  logic [31:0]                len_ext_s;
  logic [31:0]                sel_base_s;
  logic                       accept_s;
  logic                       clear_s;
  logic                       up_s;

  assign len_s     = packet_i[len_lsb_lp +: len_width_lp];
  assign len_ext_s = 32'(len_s);

  // Handshake flags depend only on state (and reset), never on ready_i.
  assign ready_o  = (state_q == e_idle) & ~reset_i;
  assign v_o      = (state_q == e_send) & ~reset_i;
  assign accept_s = v_i & ready_o;

  // Current flit is a plain indexed slice of the held packet.
  assign sel_base_s = 32'(cnt_s) * 32'(flit_width_lp);
  assign data_o     = pkt_q[sel_base_s +: flit_width_lp];

  bp_me_wormhole_flit_serializer_counter #(
    .width_p (len_width_lp)
  ) cnt_u (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_s),
    .up_i    (up_s),
    .count_o (cnt_s)
  );

  bp_me_wormhole_flit_serializer_len_chk #(
    .max_num_flit_p (max_num_flit_p),
    .len_width_p    (len_width_lp)
  ) len_chk_u (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .accept_i (accept_s),
    .len_i    (len_s)
  );

  // Next-state, packet capture and counter control.
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    last_d  = last_q;
    clear_s = 1'b0;
    up_s    = 1'b0;
    case (state_q)
      e_idle: begin
        if (v_i) begin
          state_d = e_send;
          pkt_d   = padded_width_lp'(packet_i);
          last_d  = (len_ext_s > 32'(max_num_flit_p - 1)) ? last_max_lp : len_s;
          clear_s = 1'b1;
        end else begin
          state_d = e_idle;
        end
      end
      e_send: begin
        if (ready_i) begin
          if (cnt_s == last_q) begin
            state_d = e_idle;
          end else begin
            up_s = 1'b1;
          end
        end else begin
          state_d = e_send;
        end
      end
      default: begin
        state_d = e_idle;
      end
    endcase
  end

  // State register; reset drops any packet in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Packet and last-flit-index registers, cleared so data_o never shows X.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pkt_q  <= '0;
      last_q <= '0;
    end else begin
      pkt_q  <= pkt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_bp_me_wormhole_flit_serializer.sv
// Bench for the flit serializer: a 4-flit instance (8-bit flits) and a
// 3-flit instance (9-bit flits with padding, used for len saturation).
module tb_bp_me_wormhole_flit_serializer;

  logic        clk;
  logic        reset_i;
  logic [31:0] packet_i;
  logic        v_i, ready_o, v_o, ready_i;
  logic [7:0]  data_o;

  logic [25:0] pkt3_i;
  logic        v3_i, ready3_o, v3_o, ready3_i;
  logic [8:0]  data3_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] tx_q[$];
  logic [7:0]  rx_flit[$];
  int          rx_cyc[$];
  int          accept_cyc[$];
  logic        vo_log[$];
  logic        ro_log[$];
  logic        ri_log[$];
  logic [7:0]  do_log[$];
  logic [63:0] ready_mask;
  bit          random_ready;

  bp_me_wormhole_flit_serializer dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .packet_i (packet_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .data_o   (data_o),
    .v_o      (v_o),
    .ready_i  (ready_i)
  );

  bp_me_wormhole_flit_serializer #(
    .max_num_flit_p      (3),
    .max_payload_width_p (20),
    .x_cord_width_p      (2),
    .y_cord_width_p      (2)
  ) dut3 (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .packet_i (pkt3_i),
    .v_i      (v3_i),
    .ready_o  (ready3_o),
    .data_o   (data3_o),
    .v_o      (v3_o),
    .ready_i  (ready3_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: flit k is bits [k*fw, k*fw+fw) of the zero-padded packet.
  function automatic logic [63:0] ref_slice(input logic [63:0] pkt, input int k, input int fw);
    logic [63:0] mask;
    mask = (64'd1 << fw) - 64'd1;
    return (pkt >> (k * fw)) & mask;
  endfunction

  // Reference: total flits = len+1, with len saturating at max-1.
  function automatic int ref_nflit(input int len, input int max_flits);
    return ((len > max_flits - 1) ? max_flits - 1 : len) + 1;
  endfunction

  function automatic logic [31:0] make_pkt(input logic [1:0] x, input logic [1:0] y,
                                           input logic [1:0] len, input logic [25:0] pl);
    return {pl, len, y, x};
  endfunction

  // Drives the 4-flit instance for ncyc cycles, offering tx_q back to back and logging outputs.
  task automatic run_dut(input int ncyc);
    rx_flit.delete(); rx_cyc.delete(); accept_cyc.delete();
    vo_log.delete(); ro_log.delete(); ri_log.delete(); do_log.delete();
    for (int c = 0; c < ncyc; c++) begin
      ready_i  = random_ready ? ($urandom_range(0, 3) != 0) : ((c < 64) ? ready_mask[c] : 1'b1);
      v_i      = (tx_q.size() > 0);
      packet_i = v_i ? tx_q[0] : 32'h0;
      #1;
      vo_log.push_back(v_o); ro_log.push_back(ready_o);
      ri_log.push_back(ready_i); do_log.push_back(data_o);
      if (v_o && ready_i) begin
        rx_flit.push_back(data_o);
        rx_cyc.push_back(c);
      end
      if (v_i && ready_o) begin
        void'(tx_q.pop_front());
        accept_cyc.push_back(c);
      end
      @(posedge clk); #1;
    end
    v_i = 1'b0; ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; v_i = 1'b0; ready_i = 1'b0; packet_i = 32'h0;
    v3_i = 1'b0; ready3_i = 1'b0; pkt3_i = 26'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o: got %b want 0", v_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_o: got %b want 0", ready_o); end
    checks++; if (v3_o !== 1'b0 || ready3_o !== 1'b0) begin errors++; $display("FAIL reset_dut3: got v=%b r=%b want 0 0", v3_o, ready3_o); end
    reset_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready_o !== 1'b1 || v_o !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got r=%b v=%b want 1 0", ready_o, v_o); end
  endtask

  task automatic test_single_stream();
    logic [31:0] p;
    logic [7:0]  h;
    p = make_pkt(2'd3, 2'd1, 2'd3, 26'($urandom));
    tx_q = {p}; ready_mask = '1; random_ready = 1'b0;
    run_dut(7);
    checks++; if (accept_cyc.size() !== 1 || accept_cyc[0] !== 0) begin errors++; $display("FAIL single_accept: got n=%0d want accept at cycle 0", accept_cyc.size()); end
    checks++; if (rx_flit.size() !== 4) begin errors++; $display("FAIL single_count: got %0d want 4", rx_flit.size()); end
    for (int k = 0; k < 4 && k < rx_flit.size(); k++) begin
      checks++;
      if (rx_flit[k] !== 8'(ref_slice(64'(p), k, 8)) || rx_cyc[k] !== k + 1) begin
        errors++; $display("FAIL single_flit%0d: got %h@%0d want %h@%0d", k, rx_flit[k], rx_cyc[k], 8'(ref_slice(64'(p), k, 8)), k + 1);
      end
    end
    h = (rx_flit.size() > 0) ? rx_flit[0] : 8'h00;
    checks++; if (h[1:0] !== 2'd3) begin errors++; $display("FAIL single_head_x: got %0d want 3", h[1:0]); end
    checks++; if (ro_log[5] !== 1'b1 || vo_log[5] !== 1'b0) begin errors++; $display("FAIL single_idle_t5: got r=%b v=%b want 1 0", ro_log[5], vo_log[5]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] p;
    p = make_pkt(2'd3, 2'd1, 2'd3, 26'($urandom));
    tx_q = {p}; ready_mask = ~64'h000000000000000C; random_ready = 1'b0;
    run_dut(9);
    for (int c = 2; c <= 4; c++) begin
      checks++;
      if (vo_log[c] !== 1'b1 || do_log[c] !== 8'(ref_slice(64'(p), 1, 8))) begin
        errors++; $display("FAIL bp_hold_c%0d: got v=%b d=%h want 1 %h", c, vo_log[c], do_log[c], 8'(ref_slice(64'(p), 1, 8)));
      end
    end
    checks++; if (rx_flit.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", rx_flit.size()); end
    for (int k = 0; k < 4 && k < rx_flit.size(); k++) begin
      checks++;
      if (rx_flit[k] !== 8'(ref_slice(64'(p), k, 8)) || rx_cyc[k] !== ((k == 0) ? 1 : k + 3)) begin
        errors++; $display("FAIL bp_flit%0d: got %h@%0d want %h@%0d", k, rx_flit[k], rx_cyc[k], 8'(ref_slice(64'(p), k, 8)), (k == 0) ? 1 : k + 3);
      end
    end
  endtask

  task automatic test_len0();
    logic [31:0] p1, p2;
    logic [7:0]  exp_q[$];
    int          exp_c[$];
    p1 = make_pkt(2'($urandom), 2'($urandom), 2'd0, 26'($urandom));
    p2 = make_pkt(2'($urandom), 2'($urandom), 2'd1, 26'($urandom));
    exp_q = {8'(ref_slice(64'(p1), 0, 8)), 8'(ref_slice(64'(p2), 0, 8)), 8'(ref_slice(64'(p2), 1, 8))};
    exp_c = {1, 3, 4};
    tx_q = {p1, p2}; ready_mask = '1; random_ready = 1'b0;
    run_dut(6);
    checks++; if (accept_cyc.size() !== 2 || accept_cyc[1] !== 2) begin errors++; $display("FAIL len0_accept: got n=%0d second@%0d want 2 second@2", accept_cyc.size(), accept_cyc[1]); end
    checks++; if (vo_log[2] !== 1'b0 || ro_log[2] !== 1'b1) begin errors++; $display("FAIL len0_bubble: got v=%b r=%b want 0 1", vo_log[2], ro_log[2]); end
    checks++; if (rx_flit.size() !== 3) begin errors++; $display("FAIL len0_count: got %0d want 3", rx_flit.size()); end
    for (int k = 0; k < 3 && k < rx_flit.size(); k++) begin
      checks++;
      if (rx_flit[k] !== exp_q[k] || rx_cyc[k] !== exp_c[k]) begin
        errors++; $display("FAIL len0_flit%0d: got %h@%0d want %h@%0d", k, rx_flit[k], rx_cyc[k], exp_q[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pk[3];
    logic [7:0]  exp_q[$];
    for (int i = 0; i < 3; i++) begin
      pk[i] = make_pkt(2'($urandom), 2'($urandom), 2'd3, 26'($urandom));
      for (int k = 0; k < 4; k++) exp_q.push_back(8'(ref_slice(64'(pk[i]), k, 8)));
    end
    tx_q = {pk[0], pk[1], pk[2]}; ready_mask = '1; random_ready = 1'b0;
    run_dut(15);
    checks++; if (rx_flit.size() !== 12) begin errors++; $display("FAIL b2b_count: got %0d want 12", rx_flit.size()); end
    checks++; if (accept_cyc.size() !== 3 || accept_cyc[1] !== 5 || accept_cyc[2] !== 10) begin errors++; $display("FAIL b2b_accept: got n=%0d at %0d,%0d want 3 at 5,10", accept_cyc.size(), accept_cyc[1], accept_cyc[2]); end
    checks++; if (rx_cyc.size() > 0 && rx_cyc[rx_cyc.size() - 1] !== 14) begin errors++; $display("FAIL b2b_last_cycle: got %0d want 14", rx_cyc[rx_cyc.size() - 1]); end
    for (int k = 0; k < 12 && k < rx_flit.size(); k++) begin
      checks++;
      if (rx_flit[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_flit%0d: got %h want %h", k, rx_flit[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p, q;
    p = make_pkt(2'($urandom), 2'($urandom), 2'd3, 26'($urandom));
    q = make_pkt(2'($urandom), 2'($urandom), 2'd3, 26'($urandom));
    tx_q = {p}; ready_mask = '1; random_ready = 1'b0;
    run_dut(3);
    #1;
    checks++; if (v_o !== 1'b1 || data_o !== 8'(ref_slice(64'(p), 2, 8))) begin errors++; $display("FAIL rst_mid_cnt2: got v=%b d=%h want 1 %h", v_o, data_o, 8'(ref_slice(64'(p), 2, 8))); end
    reset_i = 1'b1; ready_i = 1'b1;
    #1;
    checks++; if (v_o !== 1'b0 || ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid_during: got v=%b r=%b want 0 0", v_o, ready_o); end
    @(posedge clk); #1;
    reset_i = 1'b0; ready_i = 1'b0;
    #1;
    checks++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_after: got v=%b r=%b want 0 1", v_o, ready_o); end
    tx_q = {q};
    run_dut(7);
    checks++; if (rx_flit.size() !== 4) begin errors++; $display("FAIL rst_mid_count: got %0d want 4", rx_flit.size()); end
    for (int k = 0; k < 4 && k < rx_flit.size(); k++) begin
      checks++;
      if (rx_flit[k] !== 8'(ref_slice(64'(q), k, 8)) || rx_cyc[k] !== k + 1) begin
        errors++; $display("FAIL rst_mid_flit%0d: got %h@%0d want %h@%0d", k, rx_flit[k], rx_cyc[k], 8'(ref_slice(64'(q), k, 8)), k + 1);
      end
    end
  endtask

  task automatic test_saturate();
    logic [25:0] p3;
    logic [8:0]  got[$];
    int          lens[2];
    int          n;
    lens = '{3, 1};
    for (int i = 0; i < 2; i++) begin
      p3 = {20'($urandom), 2'(lens[i]), 2'($urandom), 2'($urandom)};
      n  = ref_nflit(lens[i], 3);
      got.delete();
      v3_i = 1'b1; pkt3_i = p3; ready3_i = 1'b1;
      #1;
      checks++; if (ready3_o !== 1'b1) begin errors++; $display("FAIL sat_ready%0d: got %b want 1", i, ready3_o); end
      @(posedge clk); #1;
      v3_i = 1'b0;
      for (int c = 1; c <= 5; c++) begin
        if (v3_o) got.push_back(data3_o);
        @(posedge clk); #1;
      end
      checks++; if (got.size() !== n) begin errors++; $display("FAIL sat_count%0d: got %0d want %0d", i, got.size(), n); end
      for (int k = 0; k < n && k < got.size(); k++) begin
        checks++;
        if (got[k] !== 9'(ref_slice(64'(p3), k, 9))) begin errors++; $display("FAIL sat_flit%0d_%0d: got %h want %h", i, k, got[k], 9'(ref_slice(64'(p3), k, 9))); end
      end
    end
    ready3_i = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] p;
    logic [7:0]  exp_q[$];
    int          len, bad;
    for (int i = 0; i < 20; i++) begin
      len = $urandom_range(0, 3);
      p   = make_pkt(2'($urandom), 2'($urandom), 2'(len), 26'($urandom));
      tx_q.push_back(p);
      for (int k = 0; k < ref_nflit(len, 4); k++) exp_q.push_back(8'(ref_slice(64'(p), k, 8)));
    end
    random_ready = 1'b1;
    run_dut(500);
    random_ready = 1'b0;
    checks++; if (accept_cyc.size() !== 20) begin errors++; $display("FAIL rand_accepts: got %0d want 20", accept_cyc.size()); end
    checks++; if (rx_flit.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", rx_flit.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < rx_flit.size(); k++) begin
      checks++;
      if (rx_flit[k] !== exp_q[k]) begin errors++; $display("FAIL rand_flit%0d: got %h want %h", k, rx_flit[k], exp_q[k]); end
    end
    bad = 0;
    for (int c = 0; c + 1 < vo_log.size(); c++) begin
      if (vo_log[c] && !ri_log[c] && (!vo_log[c + 1] || do_log[c + 1] !== do_log[c])) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rand_stable: got %0d retractions want 0", bad); end
  endtask

  initial begin
    random_ready = 1'b0;
    ready_mask   = '1;
    test_reset();
    test_single_stream();
    test_backpressure();
    test_len0();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
